// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared types and default widths for the skid pipeline stage
package pipe_pkg;

    localparam int PIPE_CTRL_W = 3;
    localparam int PIPE_DATA_W = 100;

    typedef logic [1:0] pipe_count_t;

    function automatic pipe_count_t pipe_occupancy(input logic main_valid, input logic skid_valid);
        return pipe_count_t'({1'b0, main_valid}) + pipe_count_t'({1'b0, skid_valid});
    endfunction

endpackage

// File: rtl/pipe_entry.sv
// rtl/pipe_entry.sv - one valid+ctrl+data holding register with load and clear
module pipe_entry #(
    parameter int CTRL_W = 3,
    parameter int DATA_W = 100
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              clear,
    input  logic [CTRL_W-1:0] d_ctrl,
    input  logic [DATA_W-1:0] d_data,
    output logic              valid,
    output logic [CTRL_W-1:0] q_ctrl,
    output logic [DATA_W-1:0] q_data
);

    // Clear beats load so a flush wins; ctrl is zeroed with valid so it is
    // bubble-safe straight from the register, while data keeps its last value.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid  <= 1'b0;
            q_ctrl <= '0;
            q_data <= '0;
        end else if (clear) begin
            valid  <= 1'b0;
            q_ctrl <= '0;
        end else if (load) begin
            valid  <= 1'b1;
            q_ctrl <= d_ctrl;
            q_data <= d_data;
        end
    end

endmodule

// File: rtl/pipe_stage_skid.sv
// rtl/pipe_stage_skid.sv - valid/ready pipeline stage; PIPE_SKID_BUF_EN adds a skid entry
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int CTRL_W = PIPE_CTRL_W,
    parameter int DATA_W = PIPE_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        count
);

    logic              main_valid;
    logic              main_load;
    logic              main_clear;
    logic [CTRL_W-1:0] main_d_ctrl;
    logic [DATA_W-1:0] main_d_data;
    logic              accept;
    logic              pop;

    assign accept = in_valid && in_ready;
    assign pop    = main_valid && out_ready;

`ifdef PIPE_SKID_BUF_EN
    logic              skid_valid;
    logic              skid_load;
    logic              skid_clear;
    logic [CTRL_W-1:0] skid_ctrl;
    logic [DATA_W-1:0] skid_data;

    assign in_ready = !skid_valid;

    // A held skid beat refills main on the same edge main drains.
    assign main_d_ctrl = skid_valid ? skid_ctrl : in_ctrl;
    assign main_d_data = skid_valid ? skid_data : in_data;
    assign main_load   = !flush && (skid_valid ? pop : (accept && (pop || !main_valid)));
    assign main_clear  = flush || (pop && !skid_valid && !accept);
    assign skid_load   = !flush && accept && main_valid && !pop;
    assign skid_clear  = flush || (pop && skid_valid);

    pipe_entry #(
        .CTRL_W (CTRL_W),
        .DATA_W (DATA_W)
    ) u_skid (
        .clk    (clk),
        .rst    (rst),
        .load   (skid_load),
        .clear  (skid_clear),
        .d_ctrl (in_ctrl),
        .d_data (in_data),
        .valid  (skid_valid),
        .q_ctrl (skid_ctrl),
        .q_data (skid_data)
    );

    assign count = pipe_occupancy(main_valid, skid_valid);
`else
    assign in_ready    = out_ready || !main_valid;
    assign main_d_ctrl = in_ctrl;
    assign main_d_data = in_data;
    assign main_load   = !flush && accept;
    assign main_clear  = flush || (pop && !accept);
    assign count       = pipe_occupancy(main_valid, 1'b0);
`endif

    pipe_entry #(
        .CTRL_W (CTRL_W),
        .DATA_W (DATA_W)
    ) u_main (
        .clk    (clk),
        .rst    (rst),
        .load   (main_load),
        .clear  (main_clear),
        .d_ctrl (main_d_ctrl),
        .d_data (main_d_data),
        .valid  (main_valid),
        .q_ctrl (out_ctrl),
        .q_data (out_data)
    );

    assign out_valid = main_valid;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// tb/tb_pipe_stage_skid.sv - directed and random checks of pipe_stage_skid against a queue model
module tb_pipe_stage_skid;

    localparam int CW = 3;
    localparam int DW = 100;
`ifdef PIPE_SKID_BUF_EN
    localparam int CAP = 2;
`else
    localparam int CAP = 1;
`endif

    logic          clk = 1'b0;
    logic          rst, flush, in_valid, in_ready, out_valid, out_ready;
    logic [CW-1:0] in_ctrl, out_ctrl;
    logic [DW-1:0] in_data, out_data;
    logic [1:0]    count;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [CW-1:0] c;
        logic [DW-1:0] d;
    } beat_t;

    beat_t         q[$];
    logic [DW-1:0] m_last = '0;
    int            seen_c;

    pipe_stage_skid dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_ctrl   (in_ctrl),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ctrl  (out_ctrl),
        .out_data  (out_data),
        .count     (count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic m_ready(input logic ordy);
        if (CAP == 2) return q.size() < 2;
        return q.size() == 0 || ordy;
    endfunction

    task automatic step(input logic iv, input logic [CW-1:0] c, input logic [DW-1:0] d,
                        input logic ordy, input logic fl, input logic r);
        logic rdy;
        in_valid = iv; in_ctrl = c; in_data = d; out_ready = ordy; flush = fl; rst = r;
        #1;
        rdy = m_ready(ordy);
        if (!r) check("in_ready", in_ready, rdy);
        @(posedge clk);
        if (r) begin
            q.delete();
            m_last = '0;
        end else if (fl) begin
            q.delete();
        end else begin
            if (q.size() > 0 && ordy) void'(q.pop_front());
            if (iv && rdy) q.push_back('{c: c, d: d});
        end
        if (q.size() > 0) m_last = q[0].d;
        #1;
        check("out_valid", out_valid, q.size() > 0);
        check("out_ctrl", out_ctrl, q.size() > 0 ? q[0].c : '0);
        check("out_data", out_data, m_last);
        check("count", count, q.size());
    endtask

    function automatic logic [DW-1:0] rnd_data();
        logic [127:0] t;
        t = {$urandom, $urandom, $urandom, $urandom};
        return t[DW-1:0];
    endfunction

    initial begin
        in_valid = 0; in_ctrl = '0; in_data = '0; out_ready = 0; flush = 0; rst = 1;

        step(0, '0, '0, 0, 0, 1);
        check("reset_count", count, 2'd0);
        step(0, '0, '0, 0, 0, 0);
        check("post_reset_ready", in_ready, 1'b1);

        // streaming 0x1..0x8, one cycle late
        for (int i = 1; i <= 8; i++) begin
            step(1, CW'(i), DW'(i), 1, 0, 0);
            check("stream_data", out_data, DW'(i));
            check("stream_count", count, 2'd1);
        end
        step(0, '0, '0, 1, 0, 0);

        // backpressure with 0xA then 0xB
        step(1, 3'd1, DW'('hA), 0, 0, 0);
        step(1, 3'd2, DW'('hB), 0, 0, 0);
`ifdef PIPE_SKID_BUF_EN
        check("bp_count2", count, 2'd2);
        check("bp_ready0", in_ready, 1'b0);
        step(1, 3'd3, DW'('hD), 1, 0, 0);
        check("bp_first", out_data, DW'('hB));
        step(0, '0, '0, 1, 0, 0);
`else
        check("bp_held", out_data, DW'('hA));
        check("bp_ready0", in_ready, 1'b0);
        step(1, 3'd2, DW'('hB), 1, 0, 0);
        check("bp_second", out_data, DW'('hB));
`endif
        step(0, '0, '0, 1, 0, 0);
        check("bp_drained", count, 2'd0);

        // flush with an incoming 0xC
        step(1, 3'd4, DW'('h11), 0, 0, 0);
        if (CAP == 2) step(1, 3'd5, DW'('h12), 0, 0, 0);
        step(1, 3'd6, DW'('hC), 0, 1, 0);
        check("flush_valid", out_valid, 1'b0);
        check("flush_count", count, 2'd0);
        seen_c = 0;
        for (int i = 0; i < 3; i++) begin
            step(0, '0, '0, 1, 0, 0);
            if (out_valid && out_data == DW'('hC)) seen_c++;
        end
        check("flush_no_c", seen_c, 0);

        // reset mid-stream
        step(1, 3'd1, DW'('h21), 0, 0, 0);
        step(1, 3'd2, DW'('h22), 0, 0, 0);
        step(1, 3'd3, DW'('h23), 0, 0, 1);
        check("rst_valid", out_valid, 1'b0);
        check("rst_data", out_data, '0);
        check("rst_count", count, 2'd0);
        step(1, 3'd5, DW'('h5), 1, 0, 0);
        check("rst_pass", out_data, DW'('h5));
        step(0, '0, '0, 1, 0, 0);

        // bubble gating
        for (int i = 0; i < 3; i++) begin
            step(0, 3'b111, rnd_data(), $urandom_range(0, 1), 0, 0);
            check("bubble_ctrl", out_ctrl, '0);
        end

        // random traffic
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 3) != 0, CW'($urandom), rnd_data(),
                 $urandom_range(0, 2) != 0, $urandom_range(0, 31) == 0,
                 $urandom_range(0, 63) == 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
